// File: rtl/prism_sp_tx_csum_insert.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prism_sp_tx_csum_insert: writes IP/L4 checksums from a FIFO into frames   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module prism_sp_tx_csum_insert #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_sof,
    input  logic                  i_eof,
    input  logic [37:0]           csum_rd_data,
    input  logic                  csum_empty,
    output logic                  csum_rd_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sof,
    output logic                  o_eof,
    input  logic                  o_ready,
    output logic [CNT_WIDTH-1:0]  patched_count
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t                  state;
    logic [2:0]              word_idx;
    logic [37:0]             entry;
    logic                    frame_hit;

    logic                    out_free;
    logic                    fifo_unavail;
    logic                    accept;
    logic                    forward;
    logic                    is_ipv4;
    logic [1:0]              l4_type;
    logic [15:0]             ip_csum;
    logic [15:0]             l4_csum;
    logic [15:0]             udp_csum;
    logic [DATA_WIDTH-1:0]   patched_data;
    logic                    beat_hit;
    logic                    unused_bits;

    // The pop is registered, so the head is stale for one cycle after a pop.
    assign out_free     = !o_valid || o_ready;
    assign fifo_unavail = csum_empty || csum_rd_en;
    assign i_ready      = out_free && !((state == ST_IDLE) && i_valid && i_sof && fifo_unavail);
    assign accept       = i_valid && i_ready;
    assign forward      = accept && ((state == ST_FRAME) || i_sof);

    assign is_ipv4     = (entry[1:0] == 2'b01);
    assign ip_csum     = entry[17:2];
    assign l4_type     = entry[19:18];
    assign l4_csum     = entry[35:20];
    assign udp_csum    = (l4_csum == 16'h0000) ? 16'hFFFF : l4_csum;
    assign unused_bits = ^entry[37:36];

    // word_idx holds the index of the beat currently presented in FRAME.
    always_comb begin
        patched_data = i_data;
        beat_hit     = 1'b0;
        if ((state == ST_FRAME) && is_ipv4) begin
            case (word_idx)
                3'd1: begin
                    patched_data[79:64] = {ip_csum[7:0], ip_csum[15:8]};
                    beat_hit            = 1'b1;
                end
                3'd2: begin
                    if (l4_type == 2'b10) begin
                        patched_data[79:64] = {udp_csum[7:0], udp_csum[15:8]};
                        beat_hit            = 1'b1;
                    end
                end
                3'd3: begin
                    if (l4_type == 2'b01) begin
                        patched_data[31:16] = {l4_csum[7:0], l4_csum[15:8]};
                        beat_hit            = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            word_idx      <= 3'd0;
            entry         <= 38'd0;
            frame_hit     <= 1'b0;
            csum_rd_en    <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            patched_count <= '0;
        end else begin
            csum_rd_en <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (i_sof) begin
                            entry      <= csum_rd_data;
                            csum_rd_en <= 1'b1;
                            word_idx   <= 3'd1;
                            frame_hit  <= 1'b0;
                            if (!i_eof) begin
                                state <= ST_FRAME;
                            end
                        end
                    end
                    ST_FRAME: begin
                        if (word_idx != 3'd4) begin
                            word_idx <= word_idx + 3'd1;
                        end
                        frame_hit <= frame_hit | beat_hit;
                        if (i_eof) begin
                            state <= ST_IDLE;
                            if (frame_hit || beat_hit) begin
                                patched_count <= patched_count + CNT_WIDTH'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            if (out_free) begin
                o_valid <= forward;
                if (forward) begin
                    o_data <= patched_data;
                    o_sof  <= i_sof && (state == ST_IDLE);
                    o_eof  <= i_eof;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/prism_sp_tx_csum_insert.md
PRISM_SP_TX_CSUM_INSERT -- requirements
Module: prism_sp_tx_csum_insert

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning stream word width in bits; only 128 is supported.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of the patched-frame counter.
REQ-003 SHALL have port clock  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  input beat valid.
REQ-006 SHALL have port i_ready  output  1  input beat accepted when i_valid and i_ready are both high.
REQ-007 SHALL have ports i_data  input  DATA_WIDTH, i_sof  input  1, and i_eof  input  1, carrying the frame word and frame markers; byte k is i_data[8k+:8].
REQ-008 SHALL have ports csum_rd_data  input  38, csum_empty  input  1, and csum_rd_en  output  1, forming a first-word-fall-through read side of the checksum FIFO; csum_rd_en pops one entry.
REQ-009 SHALL have ports o_valid  output  1, o_data  output  DATA_WIDTH, o_sof  output  1, and o_eof  output  1, carrying the patched frame stream.
REQ-010 SHALL have port o_ready  input  1  downstream accept.
REQ-011 SHALL have port patched_count  output  CNT_WIDTH  number of frames that received at least one checksum write.

Function
REQ-012 SHALL decode the FIFO entry as follows: [1:0] l3 type (01 = IPv4, otherwise none); [17:2] IP checksum; [19:18] l4 type (01 = TCP, 10 = UDP, otherwise none); [35:20] L4 checksum; [37:36] ignored.
REQ-013 SHALL be a single output register stage with i_ready = !o_valid || o_ready; latency is 1 cycle from an accepted input beat to o_valid.
REQ-014 SHALL implement FSM IDLE -> FRAME on an accepted SOF beat, FRAME -> IDLE on an accepted EOF beat, and IDLE -> IDLE on an accepted beat with SOF and EOF both set.
REQ-015 SHALL, in IDLE with i_valid && i_sof && csum_empty, drive i_ready low (stall) until csum_empty is low.
REQ-016 SHALL, on acceptance of a SOF beat, latch the FIFO entry and pulse csum_rd_en for exactly 1 cycle; exactly one pop SHALL occur per frame.
REQ-017 SHALL, in IDLE, drop a beat that has i_valid high and i_sof low: accept it, do not forward it, and do not pop the FIFO.
REQ-018 SHALL maintain a word index: 0 on the SOF beat, incremented per accepted beat, saturating at 4.
REQ-019 SHALL overwrite bytes using network order, with the high byte at the lower offset:
  - IPv4: word 1, bytes 8..9 <- IP checksum.
  - UDP: word 2, bytes 8..9 <- L4 checksum; a value of 0x0000 SHALL be sent as 0xFFFF.
  - TCP: word 3, bytes 2..3 <- L4 checksum.
  - The L4 overwrite SHALL apply only when the l3 type is IPv4; all other bytes pass through unchanged.
REQ-020 SHALL, when a frame ends before the target word, skip that write; the entry is still consumed.
REQ-021 SHALL increment patched_count, wrapping modulo 2^CNT_WIDTH, on the EOF beat of any frame in which at least one overwrite occurred.
REQ-022 SHALL hold o_data, o_sof, and o_eof stable while o_valid && !o_ready.
REQ-023 SHALL, when SOF is accepted and the previous frame's output beat is still pending, pop the FIFO normally; the single register stage keeps frames ordered.

Reset
REQ-024 SHALL, while reset is high, asynchronously set FSM = IDLE, word index = 0, o_valid = 0, o_sof = 0, o_eof = 0, o_data = 0, csum_rd_en = 0, patched_count = 0, and latched entry = 0.
REQ-025 SHALL, on reset mid-frame, discard the partial frame; a popped entry is not restored, and the next accepted beat is treated per REQ-017 until a SOF arrives.

Verification
REQ-026 SHALL verify the IPv4/UDP case: 4-word frame, entry l3=01, ip=0x1234, l4=10, csum=0xABCD -> word1 bytes 8,9 = 0x12,0x34; word2 bytes 8,9 = 0xAB,0xCD; one pop; patched_count = 1.
REQ-027 SHALL verify the IPv4/TCP zero-value case: 5-word TCP frame, l4 csum=0x0000 -> word3 bytes 2,3 = 0x00,0x00 (no substitution); UDP with csum 0x0000 -> 0xFF,0xFF.
REQ-028 SHALL verify the empty-FIFO stall: SOF presented with csum_empty=1 for 10 cycles -> i_ready=0 for those cycles, no o_valid; the entry is then pushed and the frame passes with 1-cycle latency.
REQ-029 SHALL verify short and non-IP frames: a single-beat frame (SOF+EOF) with entry l3=01 -> data unchanged, one pop, patched_count unchanged; entry l3=00, l4=01 -> no bytes modified.
REQ-030 SHALL verify backpressure: o_ready toggled randomly across 3 back-to-back frames -> no lost or duplicated beats, output held stable while stalled, 3 pops.
REQ-031 SHALL verify reset mid-frame: reset asserted during word 2 -> o_valid=0 immediately; a following non-SOF beat is dropped; the next frame is patched with the next FIFO entry.
